// File: rtl/access_ctrl_multi_pkg.sv
// Shared types and helpers for the access_ctrl_multi password gate.
package access_pkg;

    typedef enum logic [1:0] {
        IDLE,
        COLLECT,
        GRANTED,
        LOCKOUT
    } state_t;

    localparam logic RST_PASS_RED   = 1'b1;
    localparam logic RST_PASS_GREEN = 1'b0;

    // Widest packed password the digit extractor accepts.
    localparam int unsigned PW_MAX = 256;

    function automatic logic [31:0] pw_digit(input logic [PW_MAX-1:0] pw,
                                             input int unsigned n,
                                             input int unsigned w);
        logic [PW_MAX-1:0] sh;
        sh = pw >> (n * w);
        return sh[31:0] & ((32'd1 << w) - 32'd1);
    endfunction

endpackage

// File: rtl/access_ctrl_multi_timer.sv
// Saturating down-counter with load/clear; expired is high while the count is zero.
module access_timer #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic         clear,
    input  logic         en,
    input  logic [W-1:0] load_val,
    output logic         expired
);

    logic [W-1:0] count;

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (clear) begin
            count <= '0;
        end else if (en && count != '0) begin
            count <= count - W'(1);
        end
    end

    assign expired = (count == '0);

endmodule

// File: rtl/access_ctrl_multi.sv
// Parametrised password gate for the player load strobes.
// Optional lockout after repeated failures is built when ACCESS_LOCKOUT_EN is defined.
module access_ctrl_multi
    import access_pkg::*;
#(
    parameter int unsigned                  DIGIT_W     = 4,
    parameter int unsigned                  PASS_LEN    = 3,
    parameter int unsigned                  NUM_CH      = 2,
    parameter logic [PASS_LEN*DIGIT_W-1:0]  PASSWORD    = 12'h351,
    parameter int unsigned                  TIMEOUT     = 64,
    parameter int unsigned                  MAX_FAIL    = 3,
    parameter int unsigned                  LOCK_CYCLES = 200
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_CH-1:0]  load_in,
    input  logic [DIGIT_W-1:0] digit,
    input  logic               digit_enter,
    input  logic               logout,
    output logic [NUM_CH-1:0]  load_out,
    output logic               pass_red,
    output logic               pass_green,
    output logic               fail_pulse,
    output logic               locked_out
);

    localparam int unsigned IW = $clog2(PASS_LEN + 1);
    localparam int unsigned TW = $clog2(TIMEOUT + 2);
    localparam logic [TW-1:0] TO_LOAD = (TIMEOUT > 0) ? TW'(TIMEOUT - 1) : '0;

    state_t             state;
    logic [IW-1:0]      idx;
    logic               mismatch;
    logic [DIGIT_W-1:0] exp_digit;
    logic               cur_mis, total_mis, is_final, accept, to_expired, lock_trig;

    always_comb begin
        exp_digit = DIGIT_W'(pw_digit(PW_MAX'(PASSWORD),
                                      (state == COLLECT) ? 32'(idx) : 32'd0, DIGIT_W));
        cur_mis   = (digit != exp_digit);
        total_mis = cur_mis | ((state == COLLECT) & mismatch);
        is_final  = (state == COLLECT) ? (idx == IW'(PASS_LEN - 1)) : (PASS_LEN == 1);
        accept    = digit_enter & ((state == IDLE) | (state == COLLECT));
    end

    // Loaded with TIMEOUT-1 on each digit, so the TIMEOUT-th idle edge finds it expired.
    access_timer #(.W(TW)) u_entry_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (accept),
        .clear    (state != COLLECT),
        .en       (state == COLLECT),
        .load_val (TO_LOAD),
        .expired  (to_expired)
    );

`ifdef ACCESS_LOCKOUT_EN
    localparam int unsigned FW = $clog2(MAX_FAIL + 1);
    localparam int unsigned LW = $clog2(LOCK_CYCLES + 1);

    logic [FW-1:0] fail_cnt;
    logic          lk_expired;

    assign lock_trig = accept & is_final & total_mis & (fail_cnt == FW'(MAX_FAIL - 1));

    access_timer #(.W(LW)) u_lock_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (lock_trig),
        .clear    (state != LOCKOUT),
        .en       (state == LOCKOUT),
        .load_val (LW'(LOCK_CYCLES - 1)),
        .expired  (lk_expired)
    );
`else
    logic unused_lock_cfg;

    assign lock_trig       = 1'b0;
    assign locked_out      = 1'b0;
    assign unused_lock_cfg = ^{MAX_FAIL, LOCK_CYCLES, lock_trig};
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            idx        <= '0;
            mismatch   <= 1'b0;
            pass_red   <= RST_PASS_RED;
            pass_green <= RST_PASS_GREEN;
            fail_pulse <= 1'b0;
`ifdef ACCESS_LOCKOUT_EN
            locked_out <= 1'b0;
            fail_cnt   <= '0;
`endif
        end else begin
            fail_pulse <= 1'b0;
            unique case (state)
                IDLE, COLLECT: begin
                    if (accept && is_final) begin
                        idx      <= '0;
                        mismatch <= 1'b0;
                        if (!total_mis) begin
                            state      <= GRANTED;
                            pass_green <= 1'b1;
                            pass_red   <= 1'b0;
`ifdef ACCESS_LOCKOUT_EN
                            fail_cnt   <= '0;
`endif
                        end else begin
                            fail_pulse <= 1'b1;
                            state      <= IDLE;
`ifdef ACCESS_LOCKOUT_EN
                            fail_cnt   <= fail_cnt + FW'(1);
                            if (lock_trig) begin
                                state      <= LOCKOUT;
                                locked_out <= 1'b1;
                            end
`endif
                        end
                    end else if (accept) begin
                        state    <= COLLECT;
                        idx      <= (state == IDLE) ? IW'(1) : idx + IW'(1);
                        mismatch <= total_mis;
                    end else if (state == COLLECT && TIMEOUT != 0 && to_expired) begin
                        state    <= IDLE;
                        idx      <= '0;
                        mismatch <= 1'b0;
                    end
                end
                GRANTED: begin
                    if (logout) begin
                        state      <= IDLE;
                        pass_green <= 1'b0;
                        pass_red   <= 1'b1;
                    end
                end
                LOCKOUT: begin
`ifdef ACCESS_LOCKOUT_EN
                    if (lk_expired) begin
                        state      <= IDLE;
                        locked_out <= 1'b0;
                        fail_cnt   <= '0;
                    end
`else
                    state <= IDLE;
`endif
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign load_out = load_in & {NUM_CH{pass_green}};

endmodule

// File: tb/tb_access_ctrl_multi.sv
// Directed plus randomized bench for access_ctrl_multi against a digit-queue reference model.
module tb_access_ctrl_multi;

    localparam int DW = 4;
    localparam int PL = 3;
    localparam int NC = 2;
    localparam int TO = 64;
    localparam int MF = 3;
    localparam int LC = 200;

    int pw_digits [PL] = '{1, 5, 3};

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          digit_enter = 1'b0;
    logic          logout = 1'b0;
    logic [NC-1:0] load_in = '0;
    logic [DW-1:0] digit = '0;
    logic [NC-1:0] load_out;
    logic          pass_red, pass_green, fail_pulse, locked_out;

    int total = 0;
    int bad   = 0;

    bit m_green, m_locked, m_fpulse;
    int m_fail, m_lock_cnt, m_idle;
    int m_digs[$];

    access_ctrl_multi #(
        .DIGIT_W     (DW),
        .PASS_LEN    (PL),
        .NUM_CH      (NC),
        .PASSWORD    (12'h351),
        .TIMEOUT     (TO),
        .MAX_FAIL    (MF),
        .LOCK_CYCLES (LC)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .load_in     (load_in),
        .digit       (digit),
        .digit_enter (digit_enter),
        .logout      (logout),
        .load_out    (load_out),
        .pass_red    (pass_red),
        .pass_green  (pass_green),
        .fail_pulse  (fail_pulse),
        .locked_out  (locked_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: collect digits in a queue, judge the whole sequence once PL have arrived.
    task automatic model(input logic r, input logic de, input logic [DW-1:0] d, input logic lo);
        bit ok;
        if (r) begin
            m_green = 0; m_locked = 0; m_fpulse = 0;
            m_fail = 0; m_lock_cnt = 0; m_idle = 0;
            m_digs.delete();
            return;
        end
        m_fpulse = 0;
        if (m_locked) begin
            m_lock_cnt++;
            if (m_lock_cnt == LC) begin
                m_locked = 0;
                m_fail   = 0;
            end
        end else if (m_green) begin
            if (lo) m_green = 0;
        end else if (de) begin
            m_digs.push_back(int'(d));
            m_idle = 0;
            if (m_digs.size() == PL) begin
                ok = 1;
                for (int i = 0; i < PL; i++)
                    if (m_digs[i] != pw_digits[i]) ok = 0;
                m_digs.delete();
                if (ok) begin
                    m_green = 1;
                    m_fail  = 0;
                end else begin
                    m_fpulse = 1;
                    m_fail++;
`ifdef ACCESS_LOCKOUT_EN
                    if (m_fail == MF) begin
                        m_locked   = 1;
                        m_lock_cnt = 0;
                    end
`endif
                end
            end
        end else if (m_digs.size() > 0) begin
            m_idle++;
            if (TO != 0 && m_idle == TO) begin
                m_digs.delete();
                m_idle = 0;
            end
        end
    endtask

    task automatic step(input logic r, input logic de, input logic [DW-1:0] d,
                        input logic lo, input logic [NC-1:0] li, input string tag);
        rst = r; digit_enter = de; digit = d; logout = lo; load_in = li;
        @(posedge clk);
        model(r, de, d, lo);
        #1;
        check({tag, ":green"},  32'(pass_green), 32'(m_green));
        check({tag, ":red"},    32'(pass_red),   32'(!m_green));
        check({tag, ":fail"},   32'(fail_pulse), 32'(m_fpulse));
        check({tag, ":locked"}, 32'(locked_out), 32'(m_locked));
        check({tag, ":load"},   32'(load_out),   32'(li & {NC{m_green}}));
    endtask

    task automatic enter(input int d, input string tag);
        step(1'b0, 1'b1, DW'(d), 1'b0, NC'($urandom_range(0, 3)), tag);
    endtask

    task automatic idle(input int n, input string tag);
        for (int i = 0; i < n; i++)
            step(1'b0, 1'b0, DW'($urandom_range(0, 15)), 1'b0, NC'($urandom_range(0, 3)), tag);
    endtask

    initial begin
        step(1'b1, 1'b0, '0, 1'b0, '1, "reset");
        step(1'b1, 1'b1, 4'd1, 1'b1, '1, "reset_hold");

        enter(1, "t1_d0"); enter(5, "t1_d1"); enter(3, "t1_d2");
        step(1'b0, 1'b0, '0, 1'b0, 2'b11, "t1_load");

        step(1'b0, 1'b0, '0, 1'b1, 2'b11, "t2_logout");
        enter(1, "t2_d0"); enter(4, "t2_d1"); enter(3, "t2_d2");
        step(1'b0, 1'b0, '0, 1'b0, 2'b11, "t2_load");

        enter(1, "t3_d0"); enter(5, "t3_d1"); enter(3, "t3_d2");
        step(1'b0, 1'b1, 4'd1, 1'b1, 2'b11, "t3_logout_digit");
        step(1'b0, 1'b0, '0, 1'b0, 2'b11, "t3_load");

        enter(1, "t4_d0"); idle(TO, "t4_wait");
        enter(1, "t4_d0b"); enter(5, "t4_d1"); enter(3, "t4_d2");
        step(1'b0, 1'b0, '0, 1'b1, 2'b11, "t4_logout");
        enter(1, "t4e_d0"); idle(TO - 1, "t4e_wait"); enter(5, "t4e_d1"); enter(3, "t4e_d2");
        step(1'b0, 1'b0, '0, 1'b1, 2'b11, "t4e_logout");

`ifdef ACCESS_LOCKOUT_EN
        for (int a = 0; a < MF; a++) begin
            enter(2, "t5_bad"); enter(2, "t5_bad"); enter(2, "t5_bad");
        end
        enter(1, "t5_early"); enter(5, "t5_early"); enter(3, "t5_early");
        idle(LC - 4, "t5_wait");
        enter(1, "t5_edge");
        enter(1, "t5_d0"); enter(5, "t5_d1"); enter(3, "t5_d2");
        step(1'b0, 1'b0, '0, 1'b1, 2'b11, "t5_logout");
`endif

        enter(1, "t6_d0");
        step(1'b1, 1'b0, '0, 1'b0, 2'b11, "t6_rst_collect");
        enter(1, "t6_d0b"); enter(5, "t6_d1"); enter(3, "t6_d2");
        step(1'b1, 1'b1, 4'd1, 1'b1, 2'b11, "t6_rst_granted");
        enter(5, "t6_after"); enter(3, "t6_after");
        step(1'b1, 1'b0, '0, 1'b0, '0, "t6_rst_clean");

        for (int i = 0; i < 4000; i++) begin
            logic r, de, lo;
            logic [DW-1:0] d;
            r  = ($urandom_range(0, 499) == 0);
            lo = ($urandom_range(0, 29) == 0);
            if (((i / 500) % 2) == 0) de = ($urandom_range(0, 2) == 0);
            else                      de = ($urandom_range(0, 89) == 0);
            if ($urandom_range(0, 9) < 7) d = DW'(pw_digits[m_digs.size()]);
            else                          d = DW'($urandom_range(0, 15));
            step(r, de, d, lo, NC'($urandom_range(0, 3)), "rand");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/access_ctrl_multi.md
Name: access_ctrl_multi

Overview:
Parametrised password gate. Digits are entered one at a time; a configurable bank of load strobes passes through only after the full password is accepted. Successor to the two-channel fixed-length gate, adding:
- generic digit width, password length and channel count
- explicit logout
- an entry timeout
- optional lockout after repeated failures

Sits between the input one-shot/debounce logic and the player load registers.

Parameters:
DIGIT_W, 4, width of one password digit.
PASS_LEN, 3, number of digits per password.
NUM_CH, 2, number of gated load channels.
PASSWORD, 12'h351, packed PASS_LEN*DIGIT_W vector; digit 0 is in the LSBs and is entered first (default sequence 1,5,3).
TIMEOUT, 64, clk cycles allowed between digits in COLLECT; 0 disables the timeout.
MAX_FAIL, 3, consecutive failures that trigger lockout (lockout build only).
LOCK_CYCLES, 200, lockout duration in clk cycles (lockout build only).

Ports:
clk  input  1  system clock, rising edge.
rst  input  1  synchronous, active-high reset.
load_in  input  NUM_CH  raw load strobes, one per channel.
digit  input  DIGIT_W  current digit value.
digit_enter  input  1  single-cycle pulse; digit is sampled on the same edge.
logout  input  1  relock request, level, sampled each cycle.
load_out  output  NUM_CH  gated load strobes.
pass_red  output  1  locked indicator.
pass_green  output  1  access-granted indicator.
fail_pulse  output  1  one-cycle pulse on each rejected attempt.
locked_out  output  1  high while in LOCKOUT.

Behaviour:
- Reset values: state IDLE; load_out=0, pass_red=1, pass_green=0, fail_pulse=0, locked_out=0; all counters 0.
- Gating: load_out = load_in & {NUM_CH{pass_green}}. This is combinational from a registered pass_green, so there is zero latency once granted.
- State IDLE:
  - digit_enter → COLLECT.
  - Digit index becomes 1.
  - mismatch flag = (digit != PASSWORD digit 0).
- State COLLECT:
  - Each digit_enter compares digit against PASSWORD[idx] and ORs the result into the mismatch flag.
  - There is no early abort on a wrong digit; all PASS_LEN digits are always taken.
  - On the entry of digit PASS_LEN-1:
    - mismatch = 0 → GRANTED. pass_green=1 and pass_red=0 from the next cycle (one cycle after the final digit_enter edge).
    - mismatch = 1 → IDLE. fail_pulse=1 for one cycle; fail counter increments.
  - Timeout: if TIMEOUT≠0 and TIMEOUT cycles pass with no digit_enter → IDLE. This does not count as a failure, and no fail_pulse is issued.
- State GRANTED:
  - digit_enter is ignored.
  - logout=1 → IDLE next cycle (pass_green=0, pass_red=1). Logout wins over a simultaneous digit_enter.
  - Success clears the fail counter.
- PASS_LEN=1: the IDLE entry is also the final digit; it evaluates directly to GRANTED or IDLE.
- rst mid-operation: rst has priority over every input and returns the block to reset values in all states.
- Counters:
  - Index is $clog2(PASS_LEN+1) bits.
  - Timeout and lockout timers saturate; they never wrap.

Optional Feature:
Macro ACCESS_LOCKOUT_EN.
- Defined:
  - When the fail counter reaches MAX_FAIL → LOCKOUT. locked_out=1, pass_red=1, digit_enter ignored.
  - After LOCK_CYCLES cycles → IDLE, with the fail counter cleared.
  - logout has no effect in LOCKOUT.
- Undefined:
  - No fail counter and no LOCKOUT state; locked_out is tied 0.
  - MAX_FAIL and LOCK_CYCLES are unused.
  - fail_pulse is unchanged.

Decomposition:
- Package access_pkg holds:
  - the state enum (IDLE, COLLECT, GRANTED, LOCKOUT)
  - the reset-value constants for the indicators
  - a function extracting digit n from a packed password vector
- One sub-module, access_timer: a parametrised saturating down-counter with load/clear and an expired flag. It is instantiated twice (entry timeout, lockout).

Test Plan:
1. Reset, then digits 1,5,3 → pass_green=1 one cycle after the third pulse; load_in=2'b11 gives load_out=2'b11.
2. Digits 1,4,3 → fail_pulse for one cycle after the third pulse; pass_green stays 0; load_in=2'b11 gives load_out=2'b00.
3. GRANTED, then logout=1 together with digit_enter → IDLE next cycle; load_out=0; the digit is ignored.
4. Digit 1, then 64 idle cycles → back to IDLE with no fail_pulse; then 1,5,3 is granted.
5. With ACCESS_LOCKOUT_EN: three wrong passwords → locked_out=1; a correct 1,5,3 within 200 cycles is ignored; after 200 cycles 1,5,3 is granted.
6. rst pulsed while in COLLECT and while in GRANTED → all outputs return to reset values on the next edge.
